// File: rtl/sigmoid_backward_if.sv
// Operand/result handshake bundle for sigmoid_backward: a valid/ready pair in
// each direction carrying signed QN.QM words.
interface sigmoid_backward_if #(
  parameter int W = 18
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] grad_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] grad_out;

  modport slave (
    input  in_valid, y_in, grad_in, out_ready,
    output in_ready, out_valid, grad_out
  );

  modport master (
    output in_valid, y_in, grad_in, out_ready,
    input  in_ready, out_valid, grad_out
  );
endinterface

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: grad_out = g*y*(1-y) through one shared multiplier.
// Define SIGMOID_BWD_ROUND_EN for round-half-up scaling instead of floor.
module sigmoid_backward #(
  parameter int QN = 6,
  parameter int QM = 11
) (
  input logic               clk,
  input logic               reset,
  sigmoid_backward_if.slave bus
);
  localparam int W = QN + QM + 1;
  localparam logic signed [W-1:0] ONE = W'(1 << QM);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

  state_t              r_state;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_g;
  logic signed [W-1:0] r_d;
  logic signed [W-1:0] r_grad;
  logic                r_out_valid;

  logic signed [W-1:0]   w_mul_a;
  logic signed [W-1:0]   w_mul_b;
  logic signed [2*W-1:0] w_prod;

  function automatic logic signed [W-1:0] clamp_y(input logic signed [W-1:0] y);
    if (y[W-1]) return '0;
    else if (y > ONE) return ONE;
    else return y;
  endfunction

  function automatic logic signed [2*W-1:0] scale(input logic signed [2*W-1:0] x);
`ifdef SIGMOID_BWD_ROUND_EN
    return (x + ((2*W)'(1) <<< (QM - 1))) >>> QM;
`else
    return x >>> QM;
`endif
  endfunction

  // MUL1 forms y*(ONE-y); MUL2 reuses the same product for d*g.
  assign w_mul_a = (r_state == MUL1) ? r_y : r_d;
  assign w_mul_b = (r_state == MUL1) ? (ONE - r_y) : r_g;
  assign w_prod  = (2*W)'(w_mul_a) * (2*W)'(w_mul_b);

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.grad_out  = r_grad;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_y         <= '0;
      r_g         <= '0;
      r_d         <= '0;
      r_grad      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_y     <= clamp_y(bus.y_in);
            r_g     <= bus.grad_in;
            r_state <= MUL1;
          end
        end
        MUL1: begin
          r_d     <= W'(scale(w_prod));
          r_state <= MUL2;
        end
        MUL2: begin
          r_grad      <= W'(scale(w_prod));
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmoid_backward.sv
// Bench for sigmoid_backward: directed vector table, backpressure and reset
// sequences, and a random back-to-back stream against an arithmetic model.
module tb_sigmoid_backward;
  localparam int W   = 18;
  localparam int ONE = 2048;
`ifdef SIGMOID_BWD_ROUND_EN
  localparam int RND_EXP = 1;
`else
  localparam int RND_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sigmoid_backward_if #(.W(W)) bus ();

  sigmoid_backward dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic signed [W-1:0] y;
    logic signed [W-1:0] g;
    longint              exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Floor division for a positive divisor, from first principles.
  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    else return -(((-a) + b - 1) / b);
  endfunction

  function automatic longint sc(input longint x);
`ifdef SIGMOID_BWD_ROUND_EN
    return fdiv(x + ONE / 2, ONE);
`else
    return fdiv(x, ONE);
`endif
  endfunction

  function automatic longint model(input longint y, input longint g);
    longint yc, d;
    yc = (y < 0) ? 0 : ((y > ONE) ? ONE : y);
    d  = sc(yc * (ONE - yc));
    return sc(d * g);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE; returns once out_valid is seen (or the budget expires).
  task automatic run_op(input logic signed [W-1:0] y, input logic signed [W-1:0] g,
                        input string name, output logic signed [W-1:0] res,
                        output int lat);
    bus.y_in     = y;
    bus.grad_in  = g;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      check({name, " in_ready busy"}, longint'(bus.in_ready), 0);
      tick();
      lat++;
    end
    res = bus.grad_out;
  endtask

  logic signed [W-1:0] res;
  int                  lat;
  logic signed [W-1:0] ys[8];
  logic signed [W-1:0] gs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"half",      18'sd1024,  18'sd2048, 512};
    vecs[1] = '{"clamp_neg", -18'sd100,  18'sd2048, 0};
    vecs[2] = '{"clamp_pos", 18'sd3000,  18'sd2048, 0};
    vecs[3] = '{"sign",      18'sd1024, -18'sd2048, -512};
    vecs[4] = '{"round_y1",  18'sd1,     18'sd2048, RND_EXP};
    vecs[5] = '{"neg_small", 18'sd512,  -18'sd3,    -1};
    vecs[6] = '{"y_zero",    18'sd0,     18'sd5000, 0};
    vecs[7] = '{"y_one",     18'sd2048,  18'sd5000, 0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.y_in      = '0;
    bus.grad_in   = '0;
    reset         = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset in_ready", longint'(bus.in_ready), 1);
    check("reset out_valid", longint'(bus.out_valid), 0);
    check("reset grad_out", longint'(bus.grad_out), 0);
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].y, vecs[i].g, vecs[i].name, res, lat);
      check({vecs[i].name, " grad_out"}, longint'(res), vecs[i].exp);
      check({vecs[i].name, " latency"}, longint'(lat), 3);
      tick();
      check({vecs[i].name, " handshake out_valid"}, longint'(bus.out_valid), 0);
      check({vecs[i].name, " back to idle"}, longint'(bus.in_ready), 1);
    end

    // Backpressure: result held while a new operand waits.
    bus.out_ready = 1'b0;
    run_op(18'sd1024, 18'sd2048, "bp", res, lat);
    check("bp grad_out", longint'(res), 512);
    bus.y_in     = 18'sd1024;
    bus.grad_in  = -18'sd2048;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp hold grad_out", longint'(bus.grad_out), 512);
      check("bp hold out_valid", longint'(bus.out_valid), 1);
      check("bp hold in_ready", longint'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp release out_valid", longint'(bus.out_valid), 0);
    check("bp release in_ready", longint'(bus.in_ready), 1);
    run_op(18'sd1024, -18'sd2048, "bp next", res, lat);
    check("bp next grad_out", longint'(res), -512);
    check("bp next latency", longint'(lat), 3);
    tick();

    // Back-to-back random stream.
    for (int i = 0; i < 8; i++) begin
      ys[i] = W'($signed($urandom_range(0, 2600)) - 200);
      gs[i] = W'($urandom_range(0, (1 << W) - 1));
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic acc;
          int   guard;
          bus.y_in     = ys[i];
          bus.grad_in  = gs[i];
          bus.in_valid = 1'b1;
          guard = 0;
          do begin
            acc = bus.in_ready;
            tick();
            guard++;
          end while (!acc && guard < 20);
        end
        bus.in_valid = 1'b0;
      end
      begin
        int t_prev, t_now;
        t_prev = 0;
        t_now  = 0;
        for (int j = 0; j < 8; j++) begin
          int wait_c;
          wait_c = 0;
          while (!bus.out_valid && wait_c < 20) begin
            tick();
            wait_c++;
            t_now++;
          end
          check("stream out_valid seen", longint'(bus.out_valid), 1);
          check("stream grad_out", longint'(bus.grad_out), model(longint'(ys[j]), longint'(gs[j])));
          if (j > 0) check("stream spacing", longint'(t_now - t_prev), 4);
          t_prev = t_now;
          tick();
          t_now++;
        end
      end
    join
    tick();

    // Reset while in MUL2 drops the operation and clears the held result.
    run_op(18'sd1024, 18'sd2048, "pre rst", res, lat);
    check("pre rst grad_out", longint'(res), 512);
    tick();
    bus.y_in     = 18'sd1024;
    bus.grad_in  = 18'sd2048;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid rst out_valid", longint'(bus.out_valid), 0);
    check("mid rst grad_out", longint'(bus.grad_out), 0);
    check("mid rst in_ready", longint'(bus.in_ready), 1);
    tick();
    check("post rst no output", longint'(bus.out_valid), 0);
    run_op(18'sd512, -18'sd3, "post rst", res, lat);
    check("post rst grad_out", longint'(res), -1);
    check("post rst latency", longint'(lat), 3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
